// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the GCD-CPU memory stage.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        OP_PASS  = 3'd0,
        OP_SLT   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_BRZ   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int LOAD_LAT_MAX = 3;

endpackage

// File: rtl/mem_stage_p_dm_array.sv
// Data memory: DM_WORDS x DATA_W single-port array, synchronous byte-enabled
// write and one-cycle registered read. Contents are never reset.
module dm_array #(
    parameter int DATA_W   = 32,
    parameter int DM_WORDS = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [DATA_W/8-1:0]         be,
    input  logic                        re,
    input  logic [$clog2(DM_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DM_WORDS];

    // Byte-lane write on enable; read word captured only when a load issues
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage_p.sv
// Memory stage between XM and MW: ALU pass-through, SLT, load/store, BRZ.
// Loads wait LOAD_LAT extra cycles with in_ready held low meanwhile.
// Define MEM_SUBWORD_EN for byte/half access, sign extension and misalign
// detection; without it every access is a full word and addr[1:0] is dropped.
module mem_stage_p
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DM_WORDS = 32,
    parameter int RD_W     = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RD_W-1:0]   xm_rd,
    output logic              mw_valid,
    output logic [DATA_W-1:0] mw_data,
    output logic [RD_W-1:0]   mw_rd,
    output logic              brz_taken,
    output logic              misalign
);

    localparam int AW    = $clog2(DM_WORDS);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(LOAD_LAT_MAX + 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               is_ld, is_st, is_brz;
    logic [AW-1:0]      widx;
    logic               misal;
    logic [NB-1:0]      be;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  nl_data;
    logic [DATA_W-1:0]  ld_value;
    logic [DATA_W-1:0]  data_p1;
    logic               res_ld_p1;
    logic               ld_misal_p1;
    logic [RD_W-1:0]    pend_rd_p1;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_ld    = (op == OP_LOAD);
    assign is_st    = (op == OP_STORE);
    assign is_brz   = (op == OP_BRZ);
    assign widx     = alu_out[AW+1:2];

`ifdef MEM_SUBWORD_EN
    logic [1:0] ld_off_p1;
    logic [1:0] ld_size_p1;
    logic       ld_sext_p1;

    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] w,
        input logic [1:0]        off,
        input logic [1:0]        sz,
        input logic              sx
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (sz)
            SZ_BYTE: r = sx ? {{(DATA_W-8){b[7]}}, b}   : {{(DATA_W-8){1'b0}}, b};
            SZ_HALF: r = sx ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte enables, lane-replicated write data and alignment fault per access size
    always_comb begin
        misal = 1'b0;
        be    = '1;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                be    = NB'(1) << alu_out[1:0];
                wdata = {NB{store_data[7:0]}};
            end
            SZ_HALF: begin
                misal = alu_out[0];
                be    = NB'(3) << {alu_out[1], 1'b0};
                wdata = {(NB/2){store_data[15:0]}};
            end
            default: misal = (alu_out[1:0] != 2'b00);
        endcase
    end

    // Capture sub-word selection for the load being issued
    always_ff @(posedge clk) begin
        if (accept && is_ld) begin
            ld_off_p1  <= alu_out[1:0];
            ld_size_p1 <= size;
            ld_sext_p1 <= sign_ext;
        end
    end

    assign ld_value = ld_misal_p1 ? '0 : load_extract(rdata, ld_off_p1, ld_size_p1, ld_sext_p1);
`else
    logic unused_subword;
    assign unused_subword = ^{size, sign_ext, alu_out[1:0]};
    assign misal    = 1'b0;
    assign be       = '1;
    assign wdata    = store_data;
    assign ld_value = rdata;
`endif

    dm_array #(
        .DATA_W  (DATA_W),
        .DM_WORDS(DM_WORDS)
    ) u_dm (
        .clk  (clk),
        .we   (accept && is_st && !misal),
        .be   (be),
        .re   (accept && is_ld),
        .addr (widx),
        .wdata(wdata),
        .rdata(rdata)
    );

    // Result value for everything that is not a load
    always_comb begin
        nl_data = alu_out;
        case (op)
            OP_SLT:            nl_data = DATA_W'(alu_out[DATA_W-1]);
            OP_STORE, OP_BRZ:  nl_data = '0;
            default:           nl_data = alu_out;
        endcase
    end

    // Hold the pending load's destination and fault while the FSM waits
    always_ff @(posedge clk) begin
        if (accept && is_ld) begin
            pend_rd_p1  <= xm_rd;
            ld_misal_p1 <= misal;
        end
    end

    // ---- stage boundary: accept -> MW result register, load-latency FSM ----
    // FSM, latency counter and registered writeback outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mw_valid  <= 1'b0;
            brz_taken <= 1'b0;
            misalign  <= 1'b0;
            res_ld_p1 <= 1'b0;
            data_p1   <= '0;
            mw_rd     <= '0;
        end else begin
            mw_valid  <= 1'b0;
            brz_taken <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_ld) begin
                            if (LOAD_LAT > 0) begin
                                state <= WAIT;
                                cnt   <= CNT_W'(LOAD_LAT);
                            end else begin
                                mw_valid  <= 1'b1;
                                misalign  <= misal;
                                mw_rd     <= xm_rd;
                                res_ld_p1 <= 1'b1;
                            end
                        end else begin
                            mw_valid  <= 1'b1;
                            res_ld_p1 <= 1'b0;
                            data_p1   <= nl_data;
                            mw_rd     <= (is_st || is_brz) ? '0 : xm_rd;
                            brz_taken <= is_brz && (alu_out == '0);
                            misalign  <= is_st && misal;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        mw_valid  <= 1'b1;
                        misalign  <= ld_misal_p1;
                        mw_rd     <= pend_rd_p1;
                        res_ld_p1 <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mw_data = res_ld_p1 ? ld_value : data_p1;

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed bench for mem_stage_p (LOAD_LAT=2); expectations follow
// MEM_SUBWORD_EN when it is defined.
module tb_mem_stage_p;
    import mem_stage_pkg::*;

    localparam int DATA_W   = 32;
    localparam int DM_WORDS = 32;
    localparam int RD_W     = 5;
    localparam int LOAD_LAT = 2;
`ifdef MEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [1:0]        size;
    logic              sign_ext;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] store_data;
    logic [RD_W-1:0]   xm_rd;
    logic              mw_valid;
    logic [DATA_W-1:0] mw_data;
    logic [RD_W-1:0]   mw_rd;
    logic              brz_taken;
    logic              misalign;

    mem_stage_p #(
        .DATA_W  (DATA_W),
        .DM_WORDS(DM_WORDS),
        .RD_W    (RD_W),
        .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .size      (size),
        .sign_ext  (sign_ext),
        .alu_out   (alu_out),
        .store_data(store_data),
        .xm_rd     (xm_rd),
        .mw_valid  (mw_valid),
        .mw_data   (mw_data),
        .mw_rd     (mw_rd),
        .brz_taken (brz_taken),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] ed;
        logic [4:0]  erd;
        logic        ebrz;
        logic        emis;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] o, input logic [1:0] s, input logic x,
                                 input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                                 input logic [31:0] ed, input logic [4:0] erd,
                                 input logic eb, input logic em);
        vec_t v;
        v.op = o; v.sz = s; v.sx = x; v.alu = a; v.sd = d; v.rd = r;
        v.ed = ed; v.erd = erd; v.ebrz = eb; v.emis = em;
        return v;
    endfunction

    // Wait (bounded) for mw_valid on falling edges; returns cycles since accept
    task automatic wait_result(output int lat);
        lat = 1;
        while (!mw_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
        op = v.op; size = v.sz; sign_ext = v.sx; alu_out = v.alu;
        store_data = v.sd; xm_rd = v.rd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        chk({nm, "_vld"}, 32'(mw_valid), 32'd1);
        chk({nm, "_lat"}, 32'(lat), (v.op == 3'd2) ? 32'(1 + LOAD_LAT) : 32'd1);
        chk({nm, "_data"}, mw_data, v.ed);
        chk({nm, "_rd"}, 32'(mw_rd), 32'(v.erd));
        chk({nm, "_brz"}, 32'(brz_taken), 32'(v.ebrz));
        chk({nm, "_mis"}, 32'(misalign), 32'(v.emis));
    endtask

    initial begin
        int lat;
        bit seen;

        in_valid = 1'b0; op = 3'd0; size = 2'd2; sign_ext = 1'b0;
        alu_out = '0; store_data = '0; xm_rd = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(mw_valid), 32'd0);
        chk("rst_data", mw_data, 32'd0);
        chk("rst_rd", 32'(mw_rd), 32'd0);
        chk("rst_brz", 32'(brz_taken), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        rst = 1'b1;

        // Reset asserted mid-stream clears the registered outputs asynchronously
        run_vec(mkv(3'd0, 2'd2, 1'b0, 32'h0000ABCD, 32'h0, 5'd1, 32'h0000ABCD, 5'd1, 1'b0, 1'b0), "pre");
        @(negedge clk);
        op = 3'd0; alu_out = 32'h99; xm_rd = 5'd9; in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_data", mw_data, 32'd0);
        chk("mid_rst_rd", 32'(mw_rd), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        tbl.push_back(mkv(3'd0, 2'd2, 1'b0, 32'h00001234, 32'h0, 5'd3, 32'h00001234, 5'd3, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd1, 2'd2, 1'b0, 32'hFFFFFFF0, 32'h0, 5'd4, 32'h1, 5'd4, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd1, 2'd2, 1'b0, 32'h00000010, 32'h0, 5'd5, 32'h0, 5'd5, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd2, 1'b0, 32'h08, 32'hA1B2C3D4, 5'd7, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd0, 1'b1, 32'h0B, 32'h0, 5'd6, SUB ? 32'hFFFFFFA1 : 32'hA1B2C3D4, 5'd6, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd0, 1'b0, 32'h0B, 32'h0, 5'd6, SUB ? 32'h000000A1 : 32'hA1B2C3D4, 5'd6, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd1, 1'b0, 32'h08, 32'h0, 5'd6, SUB ? 32'h0000C3D4 : 32'hA1B2C3D4, 5'd6, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd1, 1'b1, 32'h0A, 32'h0, 5'd6, SUB ? 32'hFFFFA1B2 : 32'hA1B2C3D4, 5'd6, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd0, 1'b1, 32'h09, 32'h0, 5'd6, SUB ? 32'hFFFFFFC3 : 32'hA1B2C3D4, 5'd6, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd4, 2'd2, 1'b0, 32'h0, 32'h0, 5'd9, 32'h0, 5'd0, 1'b1, 1'b0));
        tbl.push_back(mkv(3'd4, 2'd2, 1'b0, 32'h5, 32'h0, 5'd9, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd2, 1'b0, 32'h80, 32'h55667788, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd2, 1'b0, 32'h00, 32'h0, 5'd2, 32'h55667788, 5'd2, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd0, 1'b0, 32'h01, 32'h123456EE, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd2, 1'b0, 32'h00, 32'h0, 5'd2, SUB ? 32'h5566EE88 : 32'h123456EE, 5'd2, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd2, 1'b0, 32'h04, 32'h11112222, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd2, 1'b0, 32'h06, 32'hDEADBEEF, 5'd1, 32'h0, 5'd0, 1'b0, SUB));
        tbl.push_back(mkv(3'd2, 2'd2, 1'b0, 32'h04, 32'h0, 5'd3, SUB ? 32'h11112222 : 32'hDEADBEEF, 5'd3, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd2, 1'b0, 32'h06, 32'h0, 5'd3, SUB ? 32'h0 : 32'hDEADBEEF, 5'd3, 1'b0, SUB));
        tbl.push_back(mkv(3'd7, 2'd2, 1'b0, 32'h0000CAFE, 32'h0, 5'd2, 32'h0000CAFE, 5'd2, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd2, 1'b0, 32'h0C, 32'h01020304, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd3, 2'd1, 1'b0, 32'h0E, 32'hAAAABEEF, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd3, 1'b1, 32'h0C, 32'h0, 5'd4, SUB ? 32'hBEEF0304 : 32'hAAAABEEF, 5'd4, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd1, 1'b0, 32'h0E, 32'h0, 5'd4, SUB ? 32'h0000BEEF : 32'hAAAABEEF, 5'd4, 1'b0, 1'b0));
        tbl.push_back(mkv(3'd2, 2'd1, 1'b1, 32'h05, 32'h0, 5'd4, SUB ? 32'h0 : 32'hDEADBEEF, 5'd4, 1'b0, SUB));
        tbl.push_back(mkv(3'd2, 2'd0, 1'b1, 32'h83, 32'h0, 5'd4, SUB ? 32'h00000055 : 32'h123456EE, 5'd4, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Load latency: in_ready low for two cycles, result on the third
        run_vec(mkv(3'd3, 2'd2, 1'b0, 32'h10, 32'h00000077, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0), "st10");
        @(negedge clk);
        op = 3'd2; size = 2'd2; alu_out = 32'h10; xm_rd = 5'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_rdy_t1", 32'(in_ready), 32'd0);
        chk("lat_vld_t1", 32'(mw_valid), 32'd0);
        @(negedge clk);
        chk("lat_rdy_t2", 32'(in_ready), 32'd0);
        chk("lat_vld_t2", 32'(mw_valid), 32'd0);
        @(negedge clk);
        chk("lat_vld_t3", 32'(mw_valid), 32'd1);
        chk("lat_rdy_t3", 32'(in_ready), 32'd1);
        chk("lat_data_t3", mw_data, 32'h77);
        chk("lat_rd_t3", 32'(mw_rd), 32'd8);

        // Reset while waiting discards the load and leaves memory intact
        @(negedge clk);
        op = 3'd2; alu_out = 32'h10; xm_rd = 5'd12; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wrst_in_wait", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("wrst_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mw_valid) seen = 1'b1;
        end
        chk("wrst_no_vld", 32'(seen), 32'd0);
        run_vec(mkv(3'd2, 2'd2, 1'b0, 32'h10, 32'h0, 5'd12, 32'h77, 5'd12, 1'b0, 1'b0), "wrst_mem");

        // Back-to-back non-loads give a result every cycle
        @(negedge clk);
        op = 3'd0; alu_out = 32'h100; xm_rd = 5'd10; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_vld", i), 32'(mw_valid), 32'd1);
            chk($sformatf("b2b%0d_data", i), mw_data, 32'(32'h100 + i));
            if (i < 3) alu_out = 32'(32'h101 + i);
            else in_valid = 1'b0;
        end

        // Idle: pulses low, data and rd hold
        repeat (3) begin
            @(negedge clk);
            chk("idle_vld", 32'(mw_valid), 32'd0);
            chk("idle_brz", 32'(brz_taken) | 32'(misalign), 32'd0);
            chk("idle_data", mw_data, 32'h103);
            chk("idle_rd", 32'(mw_rd), 32'd10);
        end

        // Store then load to the same word on consecutive cycles
        @(negedge clk);
        op = 3'd3; size = 2'd2; alu_out = 32'h14; store_data = 32'hFEEDF00D; xm_rd = 5'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("stld_st_vld", 32'(mw_valid), 32'd1);
        op = 3'd2; xm_rd = 5'd11;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        chk("stld_vld", 32'(mw_valid), 32'd1);
        chk("stld_lat", 32'(lat), 32'(1 + LOAD_LAT));
        chk("stld_data", mw_data, 32'hFEEDF00D);
        chk("stld_rd", 32'(mw_rd), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parametrised pipeline memory stage for the GCD-CPU datapath, sitting between the execute stage (XM) and writeback (MW). It owns the data memory and resolves each accepted instruction into a writeback result: ALU pass-through, set-less-than, load or store. It also resolves zero-test branches. It adds configurable memory read latency with an upstream stall handshake and byte/halfword access.

## Interface
- DATA_W, 32: datapath and memory word width; must be a multiple of 16.
- DM_WORDS, 32: data memory depth in words; must be a power of two.
- RD_W, 5: destination register index width.
- LOAD_LAT, 1: extra wait cycles per load; range 0..3.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  an XM instruction is present.
- in_ready  out  1  stage can accept; the transfer happens when in_valid && in_ready.
- op  in  3  operation: PASS=0, SLT=1, LOAD=2, STORE=3, BRZ=4; codes 5..7 are treated as PASS.
- size  in  2  access size: BYTE=0, HALF=1, WORD=2; code 3 is treated as WORD.
- sign_ext  in  1  sign-extend sub-word loads when set, zero-extend otherwise.
- alu_out  in  DATA_W  ALU result; this is the byte address for LOAD/STORE.
- store_data  in  DATA_W  store operand; the low bits are used for sub-word stores.
- xm_rd  in  RD_W  destination register.
- mw_valid  out  1  result valid, one-cycle pulse.
- mw_data  out  DATA_W  writeback value.
- mw_rd  out  RD_W  writeback register; 0 for STORE and BRZ.
- brz_taken  out  1  one-cycle pulse when a BRZ has alu_out == 0.
- misalign  out  1  one-cycle pulse on a misaligned access.

## Operation
- Word index is alu_out[log2(DM_WORDS)+1:2], so addresses wrap modulo DM_WORDS*4.
- PASS: mw_data = alu_out.
- SLT: mw_data = 1 if alu_out[DATA_W-1] is set, else 0.
- STORE: memory is written on the accept edge. BYTE and HALF writes use byte enables and leave the other bytes unchanged.
- LOAD: reads the word, selects the byte or half using addr[1:0], then extends according to sign_ext.
- BRZ: brz_taken = (alu_out == 0). mw_data is 0.
- Misaligned accesses are HALF with addr[0]=1, or WORD with addr[1:0] != 0. For these, the store is suppressed, a load returns 0, and misalign pulses together with mw_valid.
- FSM has two states, IDLE and WAIT.
  - IDLE → WAIT on acceptance of a LOAD when LOAD_LAT > 0. The counter is loaded with LOAD_LAT.
  - WAIT decrements the counter each cycle and returns to IDLE when the counter reaches 0, issuing the result on that edge.
  - in_ready = 1 only in IDLE.

## Timing
- Reset values: in_ready=1, mw_valid=0, mw_data=0, mw_rd=0, brz_taken=0, misalign=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Non-load result: mw_* are valid on the edge after acceptance (latency 1).
- Load result: latency 1+LOAD_LAT. in_ready is low for LOAD_LAT cycles after a load is accepted.
- Back-to-back issue: a non-load instruction accepted each cycle produces mw_valid every cycle.
- Store then load to the same word in consecutive accepted cycles: the load returns the newly stored data.
- Reset asserted in WAIT: the FSM goes to IDLE, the pending load is discarded, no mw_valid is produced, and memory is unchanged.
- When in_valid=0 in IDLE, all pulses are 0 and mw_data/mw_rd hold their last values.

## Configuration
- MEM_SUBWORD_EN defined: BYTE/HALF access, sign_ext and misalign detection behave as described above.
- MEM_SUBWORD_EN undefined:
  - size and sign_ext are ignored, and every access is a full word.
  - addr[1:0] is truncated with no fault.
  - misalign is tied to 0 and no byte-enable logic is generated.

## Structure
- Package mem_stage_pkg holds:
  - the op_e enum (PASS/SLT/LOAD/STORE/BRZ),
  - the size_e enum (BYTE/HALF/WORD),
  - the state_e enum (IDLE/WAIT),
  - the LOAD_LAT_MAX=3 constant.
- One sub-module, dm_array: a DM_WORDS×DATA_W single-port array with synchronous write, per-byte write enables, and read data registered one cycle.
- The top level holds the FSM, latency counter, sub-word extraction/extension and the output register.

## Test plan
- Reset: drive rst=0 mid-stream → all outputs 0 and in_ready=1. Release reset, then PASS alu_out=0x1234, xm_rd=3 → next cycle mw_valid=1, mw_data=0x1234, mw_rd=3.
- SLT alu_out=0xFFFFFFF0 → mw_data=1. SLT alu_out=0x10 → mw_data=0.
- STORE WORD addr 0x08 data 0xA1B2C3D4, then LOAD BYTE addr 0x0B with sign_ext=1 → mw_data=0xFFFFFFA1. The same load with sign_ext=0 → 0x000000A1. LOAD HALF addr 0x08 → 0x0000C3D4.
- LOAD_LAT=2, LOAD accepted at cycle t → in_ready=0 at t+1 and t+2, and mw_valid at t+3. Assert reset at t+1 → no mw_valid, and the state is IDLE.
- STORE WORD addr 0x06 → misalign=1 and memory is unchanged. Without MEM_SUBWORD_EN, the same store writes word 1 and misalign=0.
- BRZ alu_out=0 → brz_taken=1 and mw_rd=0. BRZ alu_out=5 → brz_taken=0. Address 0x80 with DM_WORDS=32 aliases word 0.
